// File: rtl/ifetch_ctrl_if.sv
// Fetch-side bus bundle: instruction memory port, decode handshake and redirect.
// master = fetch controller, slave = memory/decode environment.
interface ifetch_ctrl_if #(
    parameter int unsigned ADDR_W = 32
) ();
    logic [ADDR_W-1:0] inst_add;
    logic [31:0]       inst;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_inst;
    logic [ADDR_W-1:0] out_pc;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_addr;

    modport master (
        output inst_add,
        input  inst,
        output out_valid,
        input  out_ready,
        output out_inst,
        output out_pc,
        input  redirect,
        input  redirect_addr
    );

    modport slave (
        input  inst_add,
        output inst,
        input  out_valid,
        output out_ready,
        input  out_inst,
        input  out_pc,
        output redirect,
        output redirect_addr
    );
endinterface

// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: sequential PC, one-deep output register, halt/redirect handling.
// Optional feature: define IFETCH_PERF_CNT_EN to add the fetch_count handshake counter.
module ifetch_ctrl #(
    parameter logic [5:0]  HALT_OPCODE = 6'b111111,
    parameter int unsigned ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    ifetch_ctrl_if.master     bus,
    output logic              busy,
    output logic              halted
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0]       fetch_count
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic              slot_free;
    logic              is_halt;

    assign slot_free    = !bus.out_valid || bus.out_ready;
    // Only the opcode field decides a halt; the operand bits may be undriven.
    assign is_halt      = (bus.inst[31:26] == HALT_OPCODE);
    assign bus.inst_add = pc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            pc            <= '0;
            bus.out_valid <= 1'b0;
            bus.out_inst  <= '0;
            bus.out_pc    <= '0;
            busy          <= 1'b0;
            halted        <= 1'b0;
        end else begin
            case (state)
                IDLE, HALT: begin
                    if (start) begin
                        pc            <= start_addr;
                        bus.out_valid <= 1'b0;
                        state         <= FETCH;
                        busy          <= 1'b1;
                        halted        <= 1'b0;
                    end else if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                    end
                end
                FETCH: begin
                    if (bus.redirect) begin
                        pc            <= bus.redirect_addr;
                        bus.out_valid <= 1'b0;
                    end else if (slot_free) begin
                        if (is_halt) begin
                            // Slot free implies any held word is draining now.
                            bus.out_valid <= 1'b0;
                            state         <= HALT;
                            busy          <= 1'b0;
                            halted        <= 1'b1;
                        end else begin
                            bus.out_inst  <= bus.inst;
                            bus.out_pc    <= pc;
                            bus.out_valid <= 1'b1;
                            pc            <= pc + ADDR_W'(1);
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    halted <= 1'b0;
                end
            endcase
        end
    end

`ifdef IFETCH_PERF_CNT_EN
    // Counts decode handshakes since reset or the last accepted start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_count <= '0;
        end else if (start && (state != FETCH)) begin
            fetch_count <= '0;
        end else if (bus.out_valid && bus.out_ready) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Scoreboard bench for ifetch_ctrl: expected fetch stream is derived from memory contents
// and queued on start/redirect; a negedge monitor pops and compares every handshake.
module tb_ifetch_ctrl;
    localparam int unsigned ADDR_W  = 32;
    localparam logic [5:0]  HALT_OP = 6'b111111;
    localparam int          BUDGET  = 300;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] start_addr;
    logic        busy;
    logic        halted;
`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
`endif

    ifetch_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    ifetch_ctrl #(
        .HALT_OPCODE(HALT_OP),
        .ADDR_W     (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .start_addr(start_addr),
        .bus       (bus.master),
        .busy      (busy),
        .halted    (halted)
`ifdef IFETCH_PERF_CNT_EN
        ,
        .fetch_count(fetch_count)
`endif
    );

    always #5 clk = ~clk;

    // Instruction memory: 64 programmable words, synthetic non-halt words elsewhere.
    logic [31:0] mem [64];
    always_comb begin
        if (bus.inst_add < 32'd64) bus.inst = mem[bus.inst_add[5:0]];
        else                       bus.inst = {6'h01, bus.inst_add[25:0]};
    end

    exp_t        q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          hs_run = 0;
    int          first_hs = 0;
    int          last_hs = 0;
    logic [31:0] exp_halt = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a < 32'd64) return mem[a[5:0]];
        return {6'h01, a[25:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Expected stream: consecutive words from a until the first halt opcode.
    task automatic push_stream(input logic [31:0] a);
        logic [31:0] p;
        logic [31:0] w;
        exp_t        e;
        p = a;
        for (int k = 0; k < BUDGET; k++) begin
            w = mem_word(p);
            if (w[31:26] == HALT_OP) break;
            e.pc   = p;
            e.inst = w;
            q.push_back(e);
            p = p + 32'd1;
        end
        exp_halt = p;
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_handshake: got pc %0h expected no transfer", bus.out_pc);
            end else begin
                mon_e = q.pop_front();
                chk("hs_pc", 64'(bus.out_pc), 64'(mon_e.pc));
                chk("hs_inst", 64'(bus.out_inst), 64'(mon_e.inst));
            end
            hs_run++;
            if (hs_run == 1) first_hs = cyc;
            last_hs = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [31:0] a);
        q.delete();
        push_stream(a);
        hs_run     = 0;
        start      = 1'b1;
        start_addr = a;
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_pc(input string name, input logic [31:0] p);
        int n;
        n = 0;
        while (!(bus.out_valid === 1'b1 && bus.out_pc === p) && n < BUDGET) begin
            tick();
            n++;
        end
        if (n >= BUDGET) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no valid out_pc %0h required within %0d cycles", name, p, BUDGET);
        end
    endtask

    // Run until the expected stream drains and the DUT halts; optional random ready/redirect.
    task automatic wait_done(input string name, input bit rnd);
        int n;
        n = 0;
        while ((q.size() != 0 || halted !== 1'b1) && n < BUDGET) begin
            if (rnd) begin
                bus.out_ready = ($urandom_range(0, 3) != 0);
                // Two or more undelivered words guarantee the fetcher is still running.
                if (q.size() >= 2 && $urandom_range(0, 11) == 0) begin
                    bus.out_ready     = 1'b0;
                    bus.redirect      = 1'b1;
                    bus.redirect_addr = 32'($urandom_range(0, 50));
                    q.delete();
                    push_stream(bus.redirect_addr);
                end
            end
            tick();
            bus.redirect = 1'b0;
            n++;
        end
        bus.out_ready = 1'b1;
        chk({name, "_halted"}, 64'(halted), 64'd1);
        chk({name, "_busy"}, 64'(busy), 64'd0);
        chk({name, "_halt_addr"}, 64'(bus.inst_add), 64'(exp_halt));
        chk({name, "_pending"}, 64'(q.size()), 64'd0);
`ifdef IFETCH_PERF_CNT_EN
        chk({name, "_fetch_count"}, 64'(fetch_count), 64'(hs_run));
`endif
    endtask

    task automatic check_reset_state(input string name);
        chk({name, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        chk({name, "_out_inst"}, 64'(bus.out_inst), 64'd0);
        chk({name, "_out_pc"}, 64'(bus.out_pc), 64'd0);
        chk({name, "_inst_add"}, 64'(bus.inst_add), 64'd0);
        chk({name, "_busy"}, 64'(busy), 64'd0);
        chk({name, "_halted"}, 64'(halted), 64'd0);
`ifdef IFETCH_PERF_CNT_EN
        chk({name, "_fetch_count"}, 64'(fetch_count), 64'd0);
`endif
    endtask

    task automatic load_program();
        for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0000;
        mem[0] = 32'h8C03_0003;
        mem[1] = 32'h8C04_0004;
        mem[2] = 32'h8C05_0005;
        mem[3] = 32'h8C06_0002;
        mem[4] = 32'h00C5_5000;
        mem[5] = 32'h0083_5801;
        mem[6] = {HALT_OP, 26'bx};
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        logic [31:0] w;
        rst_n             = 1'b0;
        start             = 1'b0;
        start_addr        = '0;
        bus.out_ready     = 1'b0;
        bus.redirect      = 1'b0;
        bus.redirect_addr = '0;
        load_program();
        tick();
        tick();
        check_reset_state("reset");
        rst_n = 1'b1;

        // Straight-line program, latency and throughput.
        bus.out_ready = 1'b1;
        do_start(32'd0);
        chk("lat_inst_add", 64'(bus.inst_add), 64'd0);
        chk("lat_busy", 64'(busy), 64'd1);
        chk("lat_valid_early", 64'(bus.out_valid), 64'd0);
        tick();
        chk("lat_valid", 64'(bus.out_valid), 64'd1);
        chk("lat_out_pc", 64'(bus.out_pc), 64'd0);
        wait_done("basic", 1'b0);
        chk("basic_handshakes", 64'(hs_run), 64'd6);
        chk("basic_throughput", 64'(last_hs - first_hs), 64'd5);
        chk("basic_halt_addr6", 64'(bus.inst_add), 64'd6);

        // Restart from HALT, then stall three cycles on word 2.
        do_start(32'd0);
`ifdef IFETCH_PERF_CNT_EN
        chk("restart_fetch_count", 64'(fetch_count), 64'd0);
`endif
        wait_pc("stall", 32'd2);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_inst", 64'(bus.out_inst), 64'h8C05_0005);
            chk("stall_pc_reg", 64'(bus.inst_add), 64'd3);
            chk("stall_valid", 64'(bus.out_valid), 64'd1);
        end
        bus.out_ready = 1'b1;
        wait_done("stall", 1'b0);
        chk("stall_handshakes", 64'(hs_run), 64'd6);

        // Redirect to word 4 while word 1 is presented.
        do_start(32'd0);
        wait_pc("redir", 32'd1);
        bus.out_ready     = 1'b0;
        bus.redirect      = 1'b1;
        bus.redirect_addr = 32'd4;
        q.delete();
        push_stream(32'd4);
        tick();
        bus.redirect  = 1'b0;
        chk("redir_flush", 64'(bus.out_valid), 64'd0);
        chk("redir_pc", 64'(bus.inst_add), 64'd4);
        bus.out_ready = 1'b1;
        tick();
        chk("redir_out_pc", 64'(bus.out_pc), 64'd4);
        chk("redir_out_inst", 64'(bus.out_inst), 64'h00C5_5000);
        wait_done("redir", 1'b0);
        chk("redir_handshakes", 64'(hs_run), 64'd3);

        // PC wraps from all-ones to zero.
        do_start(32'hFFFF_FFFF);
        wait_done("wrap", 1'b0);
        chk("wrap_handshakes", 64'(hs_run), 64'd7);

        // Reset during a stall, then restart elsewhere.
        do_start(32'd0);
        wait_pc("rst_mid", 32'd3);
        bus.out_ready = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        q.delete();
        check_reset_state("rst_mid");
        bus.out_ready = 1'b1;
        tick();
        chk("rst_idle_busy", 64'(busy), 64'd0);
        do_start(32'd2);
        wait_done("rst_restart", 1'b0);
        chk("rst_restart_handshakes", 64'(hs_run), 64'd4);

        // Random programs with random backpressure and redirects.
        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < 63; i++) begin
                w = $urandom;
                if ($urandom_range(0, 9) == 0) w[31:26] = HALT_OP;
                else if (w[31:26] == HALT_OP)  w[26] = 1'b0;
                mem[i] = w;
            end
            mem[63] = {HALT_OP, 26'h0};
            do_start(32'($urandom_range(0, 40)));
            wait_done("rand", 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
